intersection_ctrl: RTL
======================

// Module: intersection_ctrl
// PURPOSE
// Two-direction (NS main / EW side) intersection controller; successor to the single-head light.
// Per-phase durations are parameters, and every direction change passes through an all-red clearance.
// Adds a latched pedestrian walk phase and a night flashing mode.
// Timing base is a 1 Hz tick from the existing divider; drives LED heads/PMOD on the Nexys A7 top.
// PARAMETERS
// CLK_FREQ  100_000_000  input clock Hz; passed to divider (tick period = CLK_FREQ cycles)
// GREEN_T   30           green dwell, ticks (1..2^CNT_W-1)
// YELLOW_T  4            yellow dwell, ticks (>=1)
// ALLRED_T  2            all-red clearance, ticks (>=1)
// PED_T     10           walk dwell, ticks (>=1)
// CNT_W     8            dwell counter width
// PORTS
// clk          in   1  system clock
// rst_n        in   1  asynchronous active-low reset
// ped_req      in   1  pedestrian button, sync'd level/pulse; any high cycle latches request
// night_mode   in   1  level, sync'd; request flashing operation
// ns_red/ns_yellow/ns_green  out 1 each  NS head
// ew_red/ew_yellow/ew_green  out 1 each  EW head
// walk         out  1  pedestrian walk lamp
// ped_pending  out  1  request latched, not yet served
// phase        out  3  current state code (debug)
// BEHAVIOUR
// - States: ALLRED_A, NS_GREEN, NS_YELLOW, ALLRED_B, EW_GREEN, EW_YELLOW, PED_WALK, FLASH.
// - Dwell: counter cleared on state entry, +1 per tick; leave when tick && cnt==T-1 (T ticks exactly).
// - Normal cycle: ALLRED_A(ALLRED_T) -> NS_GREEN -> NS_YELLOW -> ALLRED_B -> EW_GREEN -> EW_YELLOW -> ALLRED_A.
// - next_dir reg: set NS on ALLRED_A entry, EW on ALLRED_B entry.
// - At ALLRED_x expiry, priority: night_mode -> FLASH; else ped_pending -> PED_WALK; else green per next_dir.
// - PED_WALK: walk=1, all vehicle red; after PED_T -> green per next_dir.
// - ped_pending: set on ped_req; cleared on PED_WALK entry. In PED_WALK and FLASH, ped_req ignored.
// - Set+clear in same cycle: clear wins.
// - FLASH: flash bit toggles each tick; ns_yellow=flash, ew_red=flash, all else 0.
// - FLASH entry: ped_pending cleared, flash cleared. Exit only when night_mode low: -> ALLRED_A (next_dir NS).
// - night_mode is never honoured mid-green/yellow; it waits for the next all-red expiry.
// - Outputs are pure decode of the state, flash and ped_pending regs; exactly one lamp per head.
// - Exception: FLASH, where each head may be dark.
// - Reset (async assert, sync to clk edge on release): state=ALLRED_A, cnt=0, flash=0, next_dir=NS, ped_pending=0.
// - Outputs in reset: ns_red=ew_red=1, all other lamps and walk=0, phase=ALLRED_A.
// - Divider is reset with the same rst_n (inverted at the instance if needed).
// - Reset mid-phase: immediate return to the reset values above; no partial phases resume.
// - Illegal state code -> ALLRED_A next cycle.
// STRUCTURE
// - traffic_pkg (shared include): state codes, lamp-vector localparams, default durations.
// - Sub-module: clk_divider_1hz (existing) for tick_1hz.
// - This file contains FSM, dwell counter, ped latch and flash toggle only.
// TESTING (CLK_FREQ=10, GREEN_T=3, YELLOW_T=2, ALLRED_T=1, PED_T=2)
// 1 Reset release, idle inputs -> all-red 10 clk, NS_GREEN 30, NS_YELLOW 20, ALLRED_B 10, EW_GREEN 30, EW_YELLOW 20.
//   Then back to ALLRED_A; period = 120 clk.
// 2 ped_req 1-clk pulse during NS_GREEN -> ped_pending=1 until ALLRED_B expiry.
//   Then walk=1 for 20 clk with all red, then EW_GREEN; ped_pending=0.
// 3 ped_req held high through PED_WALK -> no re-latch; ped_pending stays 0 after walk.
// 4 night_mode raised in EW_GREEN -> EW phase completes; FLASH at ALLRED_A expiry.
//   ns_yellow/ew_red toggle every 10 clk; other lamps 0.
// 5 night_mode dropped in FLASH -> ALLRED_A for 10 clk, then NS_GREEN.
// 6 rst_n low mid NS_YELLOW, asynchronously (no clk edge) -> ns_red=ew_red=1 at once, others 0.
//   On release, sequence restarts as in test 1.
// 7 Assert in every cycle: never green/yellow on both heads simultaneously; walk implies both heads red.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared definitions for the intersection controller: phase codes, lamp vectors, default dwells.
// Latency: n/a (package).
// Backpressure: n/a.
package traffic_pkg;

   // Phase codes, also exported on the debug phase port
   typedef enum logic [2:0] {
      ALLRED_A  = 3'd0,
      NS_GREEN  = 3'd1,
      NS_YELLOW = 3'd2,
      ALLRED_B  = 3'd3,
      EW_GREEN  = 3'd4,
      EW_YELLOW = 3'd5,
      PED_WALK  = 3'd6,
      FLASH     = 3'd7
   } phase_e;

   // Which head gets the next green once the clearance (or walk) ends
   typedef enum logic {
      DIR_NS = 1'b0,
      DIR_EW = 1'b1
   } dir_e;

   // Lamp vectors per head, ordered {red, yellow, green}
   localparam logic [2:0] LAMP_OFF = 3'b000;
   localparam logic [2:0] LAMP_RED = 3'b100;
   localparam logic [2:0] LAMP_YEL = 3'b010;
   localparam logic [2:0] LAMP_GRN = 3'b001;

   // Default dwell times in 1 Hz ticks
   localparam int DEF_GREEN_T  = 30;
   localparam int DEF_YELLOW_T = 4;
   localparam int DEF_ALLRED_T = 2;
   localparam int DEF_PED_T    = 10;

endpackage

// File: rtl/clk_divider_1hz.sv
// Divides the system clock to a one-cycle tick every CLK_FREQ cycles.
// Latency: first tick CLK_FREQ-1 cycles after reset release, then every CLK_FREQ cycles.
// Backpressure: none; free-running.
module clk_divider_1hz #(
   parameter int CLK_FREQ = 100_000_000
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick_1hz
);

   localparam int W = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
   localparam logic [W-1:0] LAST = W'(CLK_FREQ - 1);

   logic [W-1:0] r_cnt;

   // Wrapping cycle counter; the tick is the terminal count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (r_cnt == LAST) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + W'(1);
      end
   end

   assign tick_1hz = (r_cnt == LAST);

endmodule

// File: rtl/intersection_ctrl.sv
// Two-head intersection controller with all-red clearance, latched walk phase and night flash.
// Latency: lamps are a direct decode of state registers; phases change on the 1 Hz tick edge.
// Backpressure: none; ped_req is latched, night_mode is honoured only at an all-red expiry.
module intersection_ctrl
   import traffic_pkg::*;
#(
   parameter int CLK_FREQ = 100_000_000,
   parameter int GREEN_T  = DEF_GREEN_T,
   parameter int YELLOW_T = DEF_YELLOW_T,
   parameter int ALLRED_T = DEF_ALLRED_T,
   parameter int PED_T    = DEF_PED_T,
   parameter int CNT_W    = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ped_req,
   input  logic       night_mode,
   output logic       ns_red,
   output logic       ns_yellow,
   output logic       ns_green,
   output logic       ew_red,
   output logic       ew_yellow,
   output logic       ew_green,
   output logic       walk,
   output logic       ped_pending,
   output logic [2:0] phase
);

   localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_T - 1);
   localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_T - 1);
   localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_T - 1);
   localparam logic [CNT_W-1:0] PED_LAST    = CNT_W'(PED_T - 1);

   logic             w_tick;
   phase_e           r_state;
   phase_e           w_next;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_last_cnt;
   logic             w_expire;
   logic             w_change;
   logic             r_flash;
   dir_e             r_next_dir;
   logic             r_ped_pending;
   phase_e           w_green_next;
   logic [2:0]       w_ns_lamp;
   logic [2:0]       w_ew_lamp;
   logic             w_walk;

   clk_divider_1hz #(
      .CLK_FREQ (CLK_FREQ)
   ) u_div (
      .clk      (clk),
      .rst_n    (rst_n),
      .tick_1hz (w_tick)
   );

   // Final dwell count for the current phase; the phase ends on the tick at this count
   always_comb begin
      w_last_cnt = '0;
      case (r_state)
         ALLRED_A, ALLRED_B:  w_last_cnt = ALLRED_LAST;
         NS_GREEN, EW_GREEN:  w_last_cnt = GREEN_LAST;
         NS_YELLOW, EW_YELLOW: w_last_cnt = YELLOW_LAST;
         PED_WALK:            w_last_cnt = PED_LAST;
         default:             w_last_cnt = '0;
      endcase
   end

   assign w_expire     = w_tick && (r_cnt == w_last_cnt);
   assign w_green_next = (r_next_dir == DIR_NS) ? NS_GREEN : EW_GREEN;

   // Next-phase selection; night mode beats a waiting pedestrian at a clearance expiry
   always_comb begin
      w_next = r_state;
      case (r_state)
         ALLRED_A, ALLRED_B: begin
            if (w_expire) begin
               if (night_mode)         w_next = FLASH;
               else if (r_ped_pending) w_next = PED_WALK;
               else                    w_next = w_green_next;
            end
         end
         NS_GREEN:  if (w_expire) w_next = NS_YELLOW;
         NS_YELLOW: if (w_expire) w_next = ALLRED_B;
         EW_GREEN:  if (w_expire) w_next = EW_YELLOW;
         EW_YELLOW: if (w_expire) w_next = ALLRED_A;
         PED_WALK:  if (w_expire) w_next = w_green_next;
         // Leave flash on a tick so the following clearance gets a full ALLRED_T
         FLASH:     if (w_tick && !night_mode) w_next = ALLRED_A;
         default:   w_next = ALLRED_A;
      endcase
   end

   assign w_change = (w_next != r_state);

   // Phase register with dwell counter, direction memory, walk latch and flash toggle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ALLRED_A;
         r_cnt         <= '0;
         r_flash       <= 1'b0;
         r_next_dir    <= DIR_NS;
         r_ped_pending <= 1'b0;
      end else begin
         r_state <= w_next;

         if (w_change) begin
            r_cnt <= '0;
         end else if (w_tick && (r_state != FLASH)) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end

         // Flash phase always starts dark; outside FLASH the bit is held clear
         if (w_next != FLASH) begin
            r_flash <= 1'b0;
         end else if ((r_state == FLASH) && w_tick) begin
            r_flash <= ~r_flash;
         end

         if (w_change && (w_next == ALLRED_A)) begin
            r_next_dir <= DIR_NS;
         end else if (w_change && (w_next == ALLRED_B)) begin
            r_next_dir <= DIR_EW;
         end

         // Clear on entry into walk or flash wins over a simultaneous request
         if (w_change && ((w_next == PED_WALK) || (w_next == FLASH))) begin
            r_ped_pending <= 1'b0;
         end else if (ped_req && (r_state != PED_WALK) && (r_state != FLASH)) begin
            r_ped_pending <= 1'b1;
         end
      end
   end

   // Lamp decode: red on both heads unless the phase grants one head or flashes
   always_comb begin
      w_ns_lamp = LAMP_RED;
      w_ew_lamp = LAMP_RED;
      w_walk    = 1'b0;
      case (r_state)
         NS_GREEN:  w_ns_lamp = LAMP_GRN;
         NS_YELLOW: w_ns_lamp = LAMP_YEL;
         EW_GREEN:  w_ew_lamp = LAMP_GRN;
         EW_YELLOW: w_ew_lamp = LAMP_YEL;
         PED_WALK:  w_walk    = 1'b1;
         FLASH: begin
            w_ns_lamp = r_flash ? LAMP_YEL : LAMP_OFF;
            w_ew_lamp = r_flash ? LAMP_RED : LAMP_OFF;
         end
         default: begin
            w_ns_lamp = LAMP_RED;
            w_ew_lamp = LAMP_RED;
         end
      endcase
   end

   assign {ns_red, ns_yellow, ns_green} = w_ns_lamp;
   assign {ew_red, ew_yellow, ew_green} = w_ew_lamp;
   assign walk        = w_walk;
   assign ped_pending = r_ped_pending;
   assign phase       = r_state;

endmodule
